// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result stage: saturation, flag generation, accumulator, result FIFO
module alu_result_stage #(
  parameter int DEPTH    = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sum,
  input  logic       in_overflow,
  input  logic       in_acc_we,
  input  logic       in_flag_we,
  input  logic       clr_sticky,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_flags,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       sticky_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [10:0]   mem [DEPTH];

  logic       accept;
  logic       pop;
  logic [7:0] r;
  logic       z;
  logic       n;
  logic       v;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (count < FULL_COUNT) && !rst;
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A negative raw sum with overflow means the true result was positive
  always_comb begin
    r = in_sum;
    if (SATURATE && in_overflow) begin
      r = in_sum[7] ? 8'h7F : 8'h80;
    end
  end

  assign z = (r == 8'h00);
  assign n = r[7];
  assign v = in_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      acc      <= 8'h00;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      sticky_v <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && in_acc_we) acc <= r;
      if (accept && in_flag_we) begin
        flag_z <= z;
        flag_n <= n;
        flag_v <= v;
      end
      // Set wins over clear so an overflow is never lost
      if (accept && v)     sticky_v <= 1'b1;
      else if (clr_sticky) sticky_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {r, z, n, v};
  end

  assign out_data  = out_valid ? mem[rd_ptr][10:3] : 8'h00;
  assign out_flags = out_valid ? mem[rd_ptr][2:0]  : 3'b000;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized and directed bench for alu_result_stage against a queue model
module tb_alu_result_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_sum = 8'h00;
  logic       in_overflow = 1'b0;
  logic       in_acc_we = 1'b0;
  logic       in_flag_we = 1'b0;
  logic       clr_sticky = 1'b0;
  logic       out_ready = 1'b0;

  logic [1:0]      o_in_ready;
  logic [1:0]      o_valid;
  logic [1:0][7:0] o_data;
  logic [1:0][2:0] o_flags;
  logic [1:0][7:0] o_acc;
  logic [1:0]      o_fz;
  logic [1:0]      o_fn;
  logic [1:0]      o_fv;
  logic [1:0]      o_sticky;

  // instance 0: DEPTH=2 saturating; instance 1: DEPTH=4 wrapping
  alu_result_stage #(.DEPTH(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .in_sum(in_sum), .in_overflow(in_overflow), .in_acc_we(in_acc_we),
    .in_flag_we(in_flag_we), .clr_sticky(clr_sticky), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_data(o_data[0]), .out_flags(o_flags[0]),
    .acc(o_acc[0]), .flag_z(o_fz[0]), .flag_n(o_fn[0]), .flag_v(o_fv[0]),
    .sticky_v(o_sticky[0])
  );

  alu_result_stage #(.DEPTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .in_sum(in_sum), .in_overflow(in_overflow), .in_acc_we(in_acc_we),
    .in_flag_we(in_flag_we), .clr_sticky(clr_sticky), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_data(o_data[1]), .out_flags(o_flags[1]),
    .acc(o_acc[1]), .flag_z(o_fz[1]), .flag_n(o_fn[1]), .flag_v(o_fv[1]),
    .sticky_v(o_sticky[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: each entry is {result, z, n, v}
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int          m_depth[2] = '{2, 4};
  bit          m_sat[2]   = '{1'b1, 1'b0};
  logic [7:0]  m_acc[2];
  logic [2:0]  m_flags[2];
  logic        m_sticky[2];

  function automatic logic [10:0] model_entry(input logic [7:0] sum, input logic ov, input bit sat);
    logic [7:0] res;
    res = sum;
    if (sat && ov) res = sum[7] ? 8'h7F : 8'h80;
    return {res, res == 8'h00, res[7], ov};
  endfunction

  task automatic model_update();
    logic [10:0] q[$];
    logic [10:0] e;
    bit acc_ok;
    for (int k = 0; k < 2; k++) begin
      q = (k == 0) ? q0 : q1;
      if (rst) begin
        q.delete();
        m_acc[k] = 8'h00;
        m_flags[k] = 3'b000;
        m_sticky[k] = 1'b0;
      end else begin
        acc_ok = in_valid && (q.size() < m_depth[k]);
        e = model_entry(in_sum, in_overflow, m_sat[k]);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc_ok) begin
          q.push_back(e);
          if (in_acc_we) m_acc[k] = e[10:3];
          if (in_flag_we) m_flags[k] = e[2:0];
          if (in_overflow) m_sticky[k] = 1'b1;
          else if (clr_sticky) m_sticky[k] = 1'b0;
        end else if (clr_sticky) begin
          m_sticky[k] = 1'b0;
        end
      end
      if (k == 0) q0 = q; else q1 = q;
    end
  endtask

  task automatic compare_all();
    logic [10:0] q[$];
    logic [10:0] head;
    for (int k = 0; k < 2; k++) begin
      q = (k == 0) ? q0 : q1;
      head = (q.size() > 0) ? q[0] : 11'h000;
      check($sformatf("i%0d_in_ready", k), o_in_ready[k], !rst && (q.size() < m_depth[k]));
      check($sformatf("i%0d_out_valid", k), o_valid[k], q.size() > 0);
      check($sformatf("i%0d_out_data", k), o_data[k], head[10:3]);
      check($sformatf("i%0d_out_flags", k), o_flags[k], head[2:0]);
      check($sformatf("i%0d_acc", k), o_acc[k], m_acc[k]);
      check($sformatf("i%0d_flags", k), {o_fz[k], o_fn[k], o_fv[k]}, m_flags[k]);
      check($sformatf("i%0d_sticky", k), o_sticky[k], m_sticky[k]);
    end
  endtask

  // Called just after a falling edge: apply inputs, compare, clock once, return after next falling edge
  task automatic cycle(input logic r, input logic v, input logic [7:0] s, input logic ov,
                       input logic awe, input logic fwe, input logic clr, input logic ordy);
    rst = r; in_valid = v; in_sum = s; in_overflow = ov;
    in_acc_we = awe; in_flag_we = fwe; clr_sticky = clr; out_ready = ordy;
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; in_sum = 8'h00; in_overflow = 1'b0;
    in_acc_we = 1'b0; in_flag_we = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0;
    #1;
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 8'h00, 0, 0, 0, 0, 0);
    idle_inputs();
    check("rst_out_valid", o_valid[0], 1'b0);
    check("rst_out_data", o_data[0], 8'h00);
    check("rst_out_flags", o_flags[0], 3'b000);
    check("rst_in_ready", o_in_ready[0], 1'b1);

    // zero result
    cycle(0, 1, 8'h00, 0, 0, 1, 0, 0);
    idle_inputs();
    check("zero_data", o_data[1], 8'h00);
    check("zero_flags", o_flags[1], 3'b100);
    check("zero_flag_z", o_fz[1], 1'b1);
    cycle(1, 0, 8'h00, 0, 0, 0, 0, 0);

    // saturation both directions
    cycle(0, 1, 8'h80, 1, 1, 1, 0, 0);
    idle_inputs();
    check("sat_pos_data", o_data[0], 8'h7F);
    check("sat_pos_flags", o_flags[0], 3'b001);
    check("wrap_raw_data", o_data[1], 8'h80);
    cycle(0, 1, 8'h7F, 1, 1, 1, 0, 1);
    idle_inputs();
    check("sat_neg_data", o_data[0], 8'h80);
    check("sat_neg_flags", o_flags[0], 3'b011);
    check("sat_neg_acc", o_acc[0], 8'h80);
    cycle(1, 0, 8'h00, 0, 0, 0, 0, 0);

    // backpressure on the DEPTH=2 instance
    cycle(0, 1, 8'h11, 0, 0, 0, 0, 0);
    cycle(0, 1, 8'h22, 0, 0, 0, 0, 0);
    check("full_in_ready", o_in_ready[0], 1'b0);
    cycle(0, 1, 8'h33, 0, 0, 0, 0, 0);
    check("held_data", o_data[0], 8'h11);
    cycle(0, 1, 8'h33, 0, 0, 0, 0, 1);
    check("pop_only_data", o_data[0], 8'h22);
    check("pop_only_ready", o_in_ready[0], 1'b1);
    cycle(0, 1, 8'h33, 0, 0, 0, 0, 1);
    check("accept_after_pop", o_data[0], 8'h33);
    cycle(0, 0, 8'h00, 0, 0, 0, 0, 1);
    check("drained", o_valid[0], 1'b0);

    // sticky set beats clear, then clear alone
    cycle(0, 1, 8'h05, 1, 0, 0, 1, 1);
    check("sticky_set_wins", o_sticky[0], 1'b1);
    cycle(0, 0, 8'h00, 0, 0, 0, 1, 1);
    check("sticky_cleared", o_sticky[0], 1'b0);

    // reset mid-operation with concurrent in_valid
    cycle(0, 1, 8'h55, 0, 1, 0, 0, 0);
    cycle(0, 1, 8'h55, 0, 1, 0, 0, 0);
    cycle(1, 1, 8'h66, 0, 1, 0, 0, 0);
    idle_inputs();
    check("mid_rst_valid", o_valid[0], 1'b0);
    check("mid_rst_acc", o_acc[0], 8'h00);
    check("mid_rst_ready", o_in_ready[0], 1'b1);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), 8'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 5));
    end
    idle_inputs();
    #1;
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
